// File: rtl/hazard_pkg.sv
// Shared constants and types for the register-write hazard scoreboard.
// Sizing here must stay consistent with the pipeline depth (EXE+MEM+WB).
package hazard_pkg;

  localparam int NUM_REGS     = 16;
  localparam int REG_W        = 4;
  localparam int CNT_W        = 2;
  localparam int MAX_INFLIGHT = 3;

  typedef logic [REG_W-1:0] reg_idx_t;
  typedef logic [CNT_W-1:0] pend_cnt_t;

  localparam pend_cnt_t CNT_MAX  = pend_cnt_t'(MAX_INFLIGHT);
  localparam pend_cnt_t CNT_ONE  = pend_cnt_t'(1);
  localparam pend_cnt_t CNT_ZERO = pend_cnt_t'(0);

  // One-hot decode of a register index, all-zero when not enabled.
  function automatic logic [NUM_REGS-1:0] idx_onehot(input logic en, input reg_idx_t idx);
    logic [NUM_REGS-1:0] vec;
    vec = {NUM_REGS{1'b0}};
    if (en) begin
      vec[idx] = 1'b1;
    end else begin
      vec = {NUM_REGS{1'b0}};
    end
    return vec;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_pending_counter.sv
// Per-register count of in-flight writes. Saturates at MAX_INFLIGHT, floors at zero,
// and pulses err for the cycle in which either limit is hit.
module pending_counter
  import hazard_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      inc,
  input  logic      dec,
  output pend_cnt_t cnt,
  output logic      nonzero_nxt,
  output logic      err
);

  pend_cnt_t cnt_r;
  pend_cnt_t cnt_nxt_s;
  logic      err_s;

  // Next count: an issue and a retire on the same register cancel out.
  always_comb begin
    cnt_nxt_s = cnt_r;
    err_s     = 1'b0;
    case ({inc, dec})
      2'b10: begin
        if (cnt_r == CNT_MAX) begin
          err_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      2'b01: begin
        if (cnt_r == CNT_ZERO) begin
          err_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      2'b11: cnt_nxt_s = cnt_r;
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign cnt         = cnt_r;
  assign nonzero_nxt = (cnt_nxt_s != CNT_ZERO);
  assign err         = err_s;

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight register writes from ID issue to WB retire and stalls IF/ID on a
// source that cannot be served. Build option: SCOREBOARD_FWD_EN (load-use stall only).
module hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             id_valid,
  input  logic             id_flush,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic [REG_W-1:0] id_dest,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             two_src,
  input  logic             ret_valid,
  input  logic [REG_W-1:0] ret_dest,
  output logic             hazard,
  output logic             busy,
  output logic             err_ovf
);

  logic [NUM_REGS-1:0] inc_vec_s;
  logic [NUM_REGS-1:0] dec_vec_s;
  logic [NUM_REGS-1:0] nz_nxt_vec_s;
  logic [NUM_REGS-1:0] err_vec_s;
  pend_cnt_t           cnt_s [NUM_REGS];

  logic     accept_s;
  logic     match1_s;
  logic     match2_s;
  logic     hazard_s;
  logic     ld_v_r;
  reg_idx_t ld_dest_r;
  logic     busy_r;
  logic     err_r;

  assign accept_s  = id_valid & id_wb_en & ~id_flush & ~hazard_s & ~freeze;
  assign inc_vec_s = idx_onehot(accept_s, id_dest);
  assign dec_vec_s = idx_onehot(ret_valid, ret_dest);

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
    pending_counter u_cnt (
      .clk         (clk),
      .rst         (rst),
      .inc         (inc_vec_s[g]),
      .dec         (dec_vec_s[g]),
      .cnt         (cnt_s[g]),
      .nonzero_nxt (nz_nxt_vec_s[g]),
      .err         (err_vec_s[g])
    );
  end

  // Source match against in-flight producers; src2 only counts when it is a real operand.
  always_comb begin
    match1_s = 1'b0;
    match2_s = 1'b0;
`ifdef SCOREBOARD_FWD_EN
    // Everything except a load result can be forwarded, so only the load-use case stalls.
    match1_s = ld_v_r && (ld_dest_r == src1);
    match2_s = two_src && ld_v_r && (ld_dest_r == src2);
`else
    match1_s = (cnt_s[src1] != CNT_ZERO);
    match2_s = two_src && (cnt_s[src2] != CNT_ZERO);
`endif
    hazard_s = ~rst & id_valid & ~id_flush & (match1_s | match2_s);
  end

  // Load tracker: remembers the load issued last cycle; a frozen pipeline keeps it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_v_r    <= 1'b0;
      ld_dest_r <= {REG_W{1'b0}};
    end else if (!freeze) begin
      ld_v_r    <= accept_s & id_mem_r_en;
      ld_dest_r <= id_dest;
    end else begin
      ld_v_r    <= ld_v_r;
      ld_dest_r <= ld_dest_r;
    end
  end

  // Busy from post-edge counts, plus sticky limit error.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      busy_r <= |nz_nxt_vec_s;
      err_r  <= err_r | (|err_vec_s);
    end
  end

  assign hazard  = hazard_s;
  assign busy    = busy_r;
  assign err_ovf = err_r;

endmodule
